ysyx_22041207_stage_reg: RTL and testbench
==========================================

Name: ysyx_22041207_stage_reg

Overview:
- Generic parametrised pipeline stage register with a valid/ready handshake on both sides.
- Replaces the fixed-width IF/ID latch, which had only flush/bubble controls, and can sit between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- The optional skid entry registers the upstream ready, so stall back-pressure does not form a combinational path through the pipeline.
- Data is held while stalled, order is preserved, and flush converts stored contents into zero bubbles.

Parameters:
- DATA_W, 96, payload width in bits (default packs 32-bit inst and 64-bit pc).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous kill of all stored entries.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  payload of the oldest entry.

Behaviour:
- Transfers: an upstream transfer occurs on an edge where in_valid && in_ready; a downstream transfer occurs where out_valid && out_ready.
- Storage: main entry (main_v, main_d) drives out_valid/out_data. When SKID=1 there is also a skid entry (skid_v, skid_d).
- Reset: rst=1 at an edge clears main_v and skid_v and zeroes main_d and skid_d. After reset: out_valid=0, out_data=0, in_ready=1.
- Flush: same effect as reset; it wins over every simultaneous transfer. An upstream beat accepted in the flush cycle is discarded, and a downstream beat presented in that cycle counts as consumed. On the next cycle out_valid=0 and out_data=0.
- SKID=0:
  - in_ready = !main_v || out_ready (combinational).
  - Upstream transfer: main_d <= in_data, main_v <= 1.
  - Downstream transfer with no upstream transfer: main_v <= 0, main_d is kept.
  - Latency is 1 cycle; full throughput.
- SKID=1 state machine, with in_ready = !skid_v (registered):
  - EMPTY: main_v=0, skid_v=0.
    - Upstream transfer -> FULL, main_d <= in_data.
  - FULL: main_v=1, skid_v=0.
    - Upstream and downstream transfers together -> FULL, main_d <= in_data.
    - Downstream transfer only -> EMPTY.
    - Upstream transfer only -> SKID, skid_d <= in_data.
  - SKID: main_v=1, skid_v=1, in_ready=0.
    - Downstream transfer -> FULL, main_d <= skid_d, skid_v <= 0.
    - Otherwise hold.
  - Latency EMPTY->out_valid is 1 cycle; steady-state throughput is 1 beat/cycle.
- Hold rule: while out_valid && !out_ready, out_data and out_valid must not change.
- Ordering: beats leave in acceptance order; none are duplicated or dropped except by flush/rst.
- Bubble semantics: out_valid=0 always pairs with out_data=0 after reset or flush. After a normal drain, out_data keeps its last value and is don't-care.
- Width: in_data/out_data pass bit-exact; no arithmetic on the payload.
- Upstream rule: the upstream must not drop in_valid or change in_data until it is accepted. The stage does not check this.

Optional Feature:
- Macro: YSYX_22041207_STAGE_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0], incremented on every edge with out_valid && !out_ready.
  - Adds output perf_bubble_cnt [31:0], incremented on every edge with !out_valid.
  - Both counters saturate at 32'hFFFFFFFF, clear on rst, and are unaffected by flush.
- Undefined: neither port nor its counter logic exists; the handshake behaves identically either way.

Test Plan:
1. Reset then stream: rst for 2 cycles, then in_valid=1 with data 0x1..0x8 on consecutive cycles and out_ready=1 -> out_valid rises 1 cycle after the first accept; outputs 0x1..0x8 appear one per cycle with no gaps; in_ready stays 1.
2. Stall with skid (SKID=1): stream 0xA, 0xB, 0xC; drop out_ready after 0xA appears -> 0xB and 0xC are accepted, then in_ready=0; out_data holds 0xB while stalled. Restoring out_ready yields 0xB then 0xC, and in_ready returns to 1 one cycle after 0xB leaves.
3. Flush in SKID state: two entries stored, assert flush together with in_valid=1 and data 0xDEAD -> next cycle out_valid=0, out_data=0, in_ready=1; 0xDEAD never appears at the output.
4. SKID=0 back-pressure: with out_ready=0 and one entry stored -> in_ready=0 combinationally. Setting out_ready=1 with in_valid=1 in the same cycle replaces the entry with no bubble.
5. Reset mid-stall: rst asserted while in SKID state -> all outputs match the reset values next cycle; with the perf macro defined, both counters read 0.
6. Perf counters (macro defined): 5 idle cycles, then one beat held for 3 stalled cycles -> perf_bubble_cnt=5 (+1 for the accept edge) and perf_stall_cnt=3.

Source files
------------

// File: rtl/ysyx_22041207_stage_reg.sv
// ysyx_22041207_stage_reg
// Generic pipeline stage register with a valid/ready handshake on both sides.
// It can sit between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
//   SKID = 1 : two-entry skid buffer. in_ready is a register output, so
//              downstream back-pressure never forms a combinational path
//              back through the pipeline.
//   SKID = 0 : single entry. in_ready = !main_v || out_ready.
//
// Reset and flush both empty the stage and zero the stored payload, so a
// bubble produced by either reads as out_valid=0 / out_data=0. Flush wins
// over any transfer presented in the same cycle.
//
// Optional feature, macro YSYX_22041207_STAGE_PERF_EN:
//   perf_stall_cnt  counts edges with out_valid && !out_ready
//   perf_bubble_cnt counts edges with !out_valid
//   Both saturate at all-ones, clear on rst and ignore flush.
module ysyx_22041207_stage_reg #(
    parameter int DATA_W = 96,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef YSYX_22041207_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    // Handshake events seen at the next rising edge.
    logic up_xfer;
    logic dn_xfer;

    assign up_xfer = in_valid && in_ready;
    assign dn_xfer = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // The state only names the occupancy; main_v_reg and skid_v_reg
            // are kept as separate flops so that out_valid and in_ready come
            // straight from registers.
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_FULL  = 2'd1,
                ST_SKID  = 2'd2
            } state_t;

            state_t            state_reg;
            logic              main_v_reg;
            logic              skid_v_reg;
            logic [DATA_W-1:0] main_d_reg;
            logic [DATA_W-1:0] skid_d_reg;

            // Occupancy state machine: main entry feeds the output, the skid
            // entry catches the one beat accepted while the output stalls.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state_reg  <= ST_EMPTY;
                    main_v_reg <= 1'b0;
                    skid_v_reg <= 1'b0;
                    main_d_reg <= '0;
                    skid_d_reg <= '0;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (up_xfer) begin
                                state_reg  <= ST_FULL;
                                main_v_reg <= 1'b1;
                                main_d_reg <= in_data;
                            end
                        end
                        ST_FULL: begin
                            if (up_xfer && dn_xfer) begin
                                // Pass-through: oldest leaves, new beat replaces it.
                                main_d_reg <= in_data;
                            end else if (dn_xfer) begin
                                // Drained; main_d is left as a don't-care value.
                                state_reg  <= ST_EMPTY;
                                main_v_reg <= 1'b0;
                            end else if (up_xfer) begin
                                // Output stalled: park the new beat in the skid entry.
                                state_reg  <= ST_SKID;
                                skid_v_reg <= 1'b1;
                                skid_d_reg <= in_data;
                            end
                        end
                        ST_SKID: begin
                            // in_ready is low here, so only a downstream transfer moves us.
                            if (dn_xfer) begin
                                state_reg  <= ST_FULL;
                                main_d_reg <= skid_d_reg;
                                skid_v_reg <= 1'b0;
                            end
                        end
                        default: begin
                            state_reg  <= ST_EMPTY;
                            main_v_reg <= 1'b0;
                            skid_v_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign in_ready  = !skid_v_reg;
            assign out_valid = main_v_reg;
            assign out_data  = main_d_reg;
        end else begin : g_single
            logic              main_v_reg;
            logic [DATA_W-1:0] main_d_reg;

            // Single entry: load on accept, go empty when drained with no refill.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    main_v_reg <= 1'b0;
                    main_d_reg <= '0;
                end else if (up_xfer) begin
                    main_v_reg <= 1'b1;
                    main_d_reg <= in_data;
                end else if (dn_xfer) begin
                    main_v_reg <= 1'b0;
                end
            end

            // Accept when empty or when the held entry leaves this same cycle.
            assign in_ready  = !main_v_reg || out_ready;
            assign out_valid = main_v_reg;
            assign out_data  = main_d_reg;
        end
    endgenerate

`ifdef YSYX_22041207_STAGE_PERF_EN
    // Event 0 = output stalled, event 1 = output empty (bubble).
    logic [1:0]  perf_evt;
    logic [31:0] perf_cnt_reg  [2];
    logic [31:0] perf_cnt_next [2];

    assign perf_evt[0] = out_valid && !out_ready;
    assign perf_evt[1] = !out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            // Saturating increment; holding at all-ones keeps the count monotonic.
            always_comb begin
                perf_cnt_next[gi] = perf_cnt_reg[gi];
                if (perf_evt[gi] && (perf_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
                    perf_cnt_next[gi] = perf_cnt_reg[gi] + 32'd1;
                end
            end

            // Counters observe the handshake only; flush does not clear them.
            always_ff @(posedge clk) begin
                if (rst) begin
                    perf_cnt_reg[gi] <= 32'd0;
                end else begin
                    perf_cnt_reg[gi] <= perf_cnt_next[gi];
                end
            end
        end
    endgenerate

    assign perf_stall_cnt  = perf_cnt_reg[0];
    assign perf_bubble_cnt = perf_cnt_reg[1];
`endif

endmodule

// File: tb/tb_ysyx_22041207_stage_reg.sv
// Bench for ysyx_22041207_stage_reg: one SKID=1 and one SKID=0 instance share
// clock, reset, flush and out_ready; each is compared every cycle against a
// queue model (capacity 2 with in_ready = not full, or capacity 1 with
// in_ready = empty || out_ready). Perf counters are modelled when the
// YSYX_22041207_STAGE_PERF_EN macro is defined.
module tb_ysyx_22041207_stage_reg;
    localparam int W = 96;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic         iv1 = 1'b0;
    logic         iv0 = 1'b0;
    logic [W-1:0] id1 = '0;
    logic [W-1:0] id0 = '0;
    logic         ir1, ov1, ir0, ov0;
    logic [W-1:0] od1, od0;
`ifdef YSYX_22041207_STAGE_PERF_EN
    logic [31:0]  ps1, pb1, ps0, pb0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    bit           z1 = 1'b0;
    bit           z0 = 1'b0;
    bit           chk_en = 1'b0;
    bit           acc1 = 1'b0;
    bit           acc0 = 1'b0;
    logic [31:0]  st1_m = '0, bu1_m = '0, st0_m = '0, bu0_m = '0;

    always #5 clk = ~clk;

    ysyx_22041207_stage_reg #(.DATA_W(W), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
`ifdef YSYX_22041207_STAGE_PERF_EN
        , .perf_stall_cnt(ps1), .perf_bubble_cnt(pb1)
`endif
    );

    ysyx_22041207_stage_reg #(.DATA_W(W), .SKID(0)) u_single (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
`ifdef YSYX_22041207_STAGE_PERF_EN
        , .perf_stall_cnt(ps0), .perf_bubble_cnt(pb0)
`endif
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input bit ev);
        return (ev && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    // One clock cycle: inputs already driven; compare, advance model at the edge.
    task automatic step();
        bit rdy1, rdy0, push1, push0, pop1, pop0;
        #1;
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || out_ready;
        if (chk_en) begin
            check_eq("skid_out_valid", W'(ov1), W'(q1.size() > 0));
            check_eq("skid_in_ready", W'(ir1), W'(rdy1));
            if (q1.size() > 0) check_eq("skid_out_data", od1, q1[0]);
            else if (z1) check_eq("skid_bubble_data", od1, '0);
            check_eq("single_out_valid", W'(ov0), W'(q0.size() > 0));
            check_eq("single_in_ready", W'(ir0), W'(rdy0));
            if (q0.size() > 0) check_eq("single_out_data", od0, q0[0]);
            else if (z0) check_eq("single_bubble_data", od0, '0);
`ifdef YSYX_22041207_STAGE_PERF_EN
            check_eq("skid_perf_stall", W'(ps1), W'(st1_m));
            check_eq("skid_perf_bubble", W'(pb1), W'(bu1_m));
            check_eq("single_perf_stall", W'(ps0), W'(st0_m));
            check_eq("single_perf_bubble", W'(pb0), W'(bu0_m));
`endif
        end
        push1 = iv1 && rdy1;
        push0 = iv0 && rdy0;
        pop1  = (q1.size() > 0) && out_ready;
        pop0  = (q0.size() > 0) && out_ready;
        acc1  = push1;
        acc0  = push0;
        @(posedge clk);
        if (rst) begin
            st1_m = '0; bu1_m = '0; st0_m = '0; bu0_m = '0;
        end else begin
            st1_m = sat_inc(st1_m, (q1.size() > 0) && !out_ready);
            bu1_m = sat_inc(bu1_m, q1.size() == 0);
            st0_m = sat_inc(st0_m, (q0.size() > 0) && !out_ready);
            bu0_m = sat_inc(bu0_m, q0.size() == 0);
        end
        if (rst || flush) begin
            q1.delete(); q0.delete();
            z1 = 1'b1; z0 = 1'b1;
        end else begin
            if (pop1) begin
                $display("skid   beat out 0x%0h", q1[0]);
                void'(q1.pop_front());
            end
            if (pop0) begin
                $display("single beat out 0x%0h", q0[0]);
                void'(q0.pop_front());
            end
            if (push1) begin q1.push_back(id1); z1 = 1'b0; end
            if (push0) begin q0.push_back(id0); z0 = 1'b0; end
        end
        chk_en = 1'b1;
        #1;
    endtask

    task automatic drv(input bit iv, input logic [W-1:0] d, input bit o, input bit f);
        iv1 = iv; iv0 = iv; id1 = d; id0 = d;
        out_ready = o; flush = f;
        step();
        flush = 1'b0;
    endtask

    initial begin
        // Reset for two cycles, then stream 1..8 at full rate
        rst = 1'b1;
        drv(0, '0, 0, 0);
        drv(0, '0, 0, 0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) drv(1, W'(k), 1, 0);
        drv(0, '0, 1, 0);
        drv(0, '0, 1, 0);

        // Stall with skid: A leaves, B stalls at output, C fills skid
        drv(1, W'(32'hA), 1, 0);
        drv(1, W'(32'hB), 1, 0);
        drv(1, W'(32'hC), 0, 0);
        drv(0, '0, 0, 0);
        drv(0, '0, 0, 0);
        drv(0, '0, 1, 0);
        drv(0, '0, 1, 0);
        drv(0, '0, 1, 0);

        // Flush with two entries stored and a beat offered
        drv(1, W'(32'h11), 0, 0);
        drv(1, W'(32'h22), 0, 0);
        drv(1, W'(32'hDEAD), 0, 1);
        drv(0, '0, 1, 0);
        drv(0, '0, 1, 0);

        // Single-entry back-pressure then same-cycle replace
        drv(1, W'(32'h33), 0, 0);
        drv(0, '0, 0, 0);
        drv(1, W'(32'h44), 1, 0);
        drv(0, '0, 1, 0);

        // Reset while stalled with two entries
        drv(1, W'(32'h55), 0, 0);
        drv(1, W'(32'h66), 0, 0);
        rst = 1'b1;
        drv(1, W'(32'h77), 0, 0);
        rst = 1'b0;
        drv(0, '0, 0, 0);

        // Perf pattern: 5 idle, one beat stalled 3 cycles
        rst = 1'b1;
        drv(0, '0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) drv(0, '0, 0, 0);
        drv(1, W'(32'h99), 0, 0);
        for (int k = 0; k < 3; k++) drv(0, '0, 0, 0);
`ifdef YSYX_22041207_STAGE_PERF_EN
        check_eq("perf_pattern_stall", W'(ps1), W'(32'd3));
        check_eq("perf_pattern_bubble", W'(pb1), W'(32'd6));
`endif
        drv(0, '0, 1, 0);

        // Randomized traffic; each side holds its beat until accepted
        iv1 = 1'b0; iv0 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            int thr;
            thr = (c / 100) % 3 == 0 ? 85 : ((c / 100) % 3 == 1 ? 40 : 10);
            if (!iv1 || acc1) begin
                iv1 = ($urandom_range(0, 3) != 0);
                id1 = {$urandom, $urandom, $urandom};
            end
            if (!iv0 || acc0) begin
                iv0 = ($urandom_range(0, 3) != 0);
                id0 = {$urandom, $urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 99) < thr);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            step();
        end
        flush = 1'b0;
        rst   = 1'b0;
        iv1   = 1'b0;
        iv0   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
